// File: rtl/sync_down_counter_pkg.sv
// Shared definitions for the down-counter: state encodings, default width, bench clock timing.
package sync_down_counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH  = 4;
  localparam int TB_HALF_PERIOD = 50;

endpackage

// File: rtl/sync_down_counter.sv
// Loadable down-counter/timer with a one-cycle done pulse on expiry; reset > load > en.
// Define AUTO_RELOAD_EN to reload from the stored period on expiry instead of stopping.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] period, period_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             done_nxt;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    period_nxt = period;
    done_nxt   = 1'b0;
    if (load) begin
      count_nxt  = load_val;
      period_nxt = load_val;
      if (load_val != '0) begin
        state_nxt = ST_RUN;
      end else begin
        // A zero load expires immediately without ever entering RUN.
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
    end else if (state == ST_RUN && en) begin
      if (count == ONE) begin
        done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
        count_nxt = period;
`else
        count_nxt = '0;
        state_nxt = ST_IDLE;
`endif
      end else begin
        count_nxt = count - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      period <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      period <= period_nxt;
      done   <= done_nxt;
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// Bench for sync_down_counter: directed scenarios plus random traffic, scored against a timer model.
module tb_sync_down_counter;
  import sync_down_counter_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  int edge_no = 0;

  exp_t exp_q[$];

  // Timer model: remaining ticks, armed flag, programmed period, pending pulse.
  int m_remain = 0;
  int m_period = 0;
  bit m_armed  = 0;
  bit m_pulse  = 0;

  sync_down_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .load_val(load_val), .count(count), .busy(busy), .done(done)
  );

  always #(TB_HALF_PERIOD) clk = ~clk;

  function automatic void model_edge(bit r, bit l, bit e, int v);
    m_pulse = 0;
    if (r) begin
      m_remain = 0; m_period = 0; m_armed = 0;
    end else if (l) begin
      m_remain = v; m_period = v;
      m_armed  = (v != 0);
      m_pulse  = (v == 0);
    end else if (m_armed && e) begin
      m_remain = m_remain - 1;
      if (m_remain == 0) begin
        m_pulse = 1;
`ifdef AUTO_RELOAD_EN
        m_remain = m_period;
`else
        m_armed = 0;
`endif
      end
    end
  endfunction

  function automatic void push_expect();
    exp_t x;
    x.count = W'(m_remain);
    x.busy  = m_armed;
    x.done  = m_pulse;
    exp_q.push_back(x);
  endfunction

  // Drive inputs for the next rising edge and record what that edge must produce.
  task automatic cyc(input bit r, input bit l, input bit e, input int v);
    @(negedge clk);
    reset = r; load = l; en = e; load_val = W'(v);
    model_edge(r, l, e, v);
    push_expect();
  endtask

  // Monitor: after each rising edge, score the outputs against the oldest expectation.
  initial begin
    exp_t want;
    forever begin
      @(posedge clk);
      #(TB_HALF_PERIOD / 5);
      edge_no++;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        total++;
        if ($isunknown({count, busy, done}) ||
            count !== want.count || busy !== want.busy || done !== want.done) begin
          bad++;
          $display("FAIL outputs@edge%0d got count=%0d busy=%b done=%b want count=%0d busy=%b done=%b",
                   edge_no, count, busy, done, want.count, want.busy, want.done);
        end
      end
    end
  end

  initial begin
    // Reset held across the first rising edge, released at t=125.
    model_edge(1, 0, 0, 0);
    push_expect();
    #125 reset = 1'b0;

    cyc(0, 0, 0, 0);
    // Load 5 then count down with en held high.
    cyc(0, 1, 0, 5);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);

    // Load 9 with en alternating.
    cyc(0, 1, 0, 9);
    for (int i = 0; i < 20; i++) cyc(0, 0, (i % 2) == 0, 0);

    // Load 6, reach 3, then reload 2 with en high on the same edge.
    cyc(0, 1, 0, 6);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

    // Zero load: immediate pulse, never busy; en while idle is ignored.
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    // Reset mid-count at count=4 aborts silently.
    cyc(0, 1, 0, 7);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    // Maximum load value runs the full range without wrapping.
    cyc(0, 1, 0, (1 << W) - 1);
    for (int i = 0; i < (1 << W) + 2; i++) cyc(0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 70,
          $urandom_range(0, (1 << W) - 1));
    end

    cyc(0, 0, 0, 0);
    @(posedge clk);
    #(TB_HALF_PERIOD / 2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
